// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier controller: low WIDTH bits of a*b, using the shared ALU for ADD only.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_sequencer #(
  parameter int         WIDTH   = 64,
  parameter logic [3:0] ALU_ADD = 4'b0010
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_STEP = 2'd1, S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, mp_q, mp_d, prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             add_cyc, last_shift;

  assign add_cyc = (state_q == S_STEP) && mp_q[0];

`ifdef MUL_EARLY_EXIT_EN
  assign last_shift = (mp_q[WIDTH-1:1] == '0) || (cnt_q == CW'(WIDTH-1));
`else
  assign last_shift = (cnt_q == CW'(WIDTH-1));
`endif

  assign alu_a    = add_cyc ? acc_q : '0;
  assign alu_b    = add_cyc ? mc_q  : '0;
  assign alu_ctrl = add_cyc ? ALU_ADD : 4'b0000;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign product  = prod_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          mc_d    = op_a;
          mp_d    = op_b;
          cnt_d   = '0;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (mp_q[0]) begin
          // clearing bit 0 turns the next cycle into the shift for this bit
          acc_d   = alu_result;
          mp_d[0] = 1'b0;
        end else begin
          mc_d  = mc_q << 1;
          mp_d  = mp_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (last_shift) begin
            prod_d  = acc_q;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural ALU and an expected-result queue.
module tb_mul_sequencer;
  localparam int W = 64;
  localparam int BOUND = 300;

  typedef struct {
    logic [W-1:0] prod;
    int           n;
    int           adds;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, done;
  logic [W-1:0] product, alu_a, alu_b, alu_result;
  logic [3:0]   alu_ctrl;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  mul_sequencer #(.WIDTH(W), .ALU_ADD(4'b0010)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  assign alu_result = (alu_ctrl == 4'b0010) ? alu_a + alu_b : '0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_n(input logic [W-1:0] b);
    int hb;
    hb = -1;
    for (int i = 0; i < W; i++) if (b[i]) hb = i;
`ifdef MUL_EARLY_EXIT_EN
    return ((hb < 0) ? 1 : hb + 1) + $countones(b);
`else
    return W + $countones(b);
`endif
  endfunction

  // Drive a request on a falling edge; returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    e.prod = a * b;
    e.n    = exp_n(b);
    e.adds = $countones(b);
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Called just after the accepting edge; measures latency and ADD cycles.
  task automatic collect(input string tag);
    exp_t e;
    int   j, adds;
    j = 0;
    adds = 0;
    @(negedge clk);
    while (!done && j < BOUND) begin
      if (alu_ctrl == 4'b0010) adds++;
      @(negedge clk);
      j++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_busy_in_done"}, {63'd0, busy}, 64'd1);
    chk({tag, "_product"}, product, e.prod);
    chk({tag, "_latency"}, W'(j), W'(e.n));
    chk({tag, "_adds"}, W'(adds), W'(e.adds));
    @(negedge clk);
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
    chk({tag, "_product_held"}, product, e.prod);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    #20;
    reset_n = 1'b1;

    launch(64'd7, 64'd6, 1'b0, 1'b1);                     collect("m7x6");
    launch(64'd12345, 64'd0, 1'b0, 1'b1);                 collect("m_b0");
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b1);   collect("m_neg1x3");
    launch(64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 1'b1); collect("m_trunc");
    chk("trunc_prod_val", product, 64'd0);

    // Operands and start held while busy; the second request starts only after busy falls.
    launch(64'd5, 64'd5, 1'b1, 1'b1);
    op_a = 64'd9;
    op_b = 64'd9;
    collect("m5x5_hold");
    sb.push_back('{prod: 64'd81, n: exp_n(64'd9), adds: 2});
    @(posedge clk);
    #1;
    start = 1'b0;
    collect("m9x9");

    ra = {$urandom(), $urandom()};
    rb = {$urandom(), $urandom()};
    launch(ra, rb, 1'b0, 1'b1); collect("m_rand0");
    ra = {$urandom(), $urandom()};
    rb = 64'h8000_0000_0000_0001;
    launch(ra, rb, 1'b0, 1'b1); collect("m_rand1");

    // Reset in the middle of an operation: outputs must clear before the next edge.
    launch(64'd7, 64'd6, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_product", product, 64'd0);
    chk("mid_rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
    chk("mid_rst_alu_b", alu_b, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("post_rst_idle", {63'd0, busy}, 64'd0);
    launch(64'd3, 64'd4, 1'b0, 1'b1); collect("m3x4");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle 64-bit multiplier controller that computes the low WIDTH bits of a × b by shift-and-add. It sequences the shared datapath ALU and uses only its ADD operation; shifts are done internally. It sits beside the ALU in the execute stage and drives the ALU operand/control inputs while busy. Requesters use a start/busy/done handshake.

## Interface
- WIDTH, 64, operand/product width
- ALU_ADD, 4'b0010, ALU control code for ADD
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_a  input  WIDTH  multiplicand; latched on accepted start
- op_b  input  WIDTH  multiplier; latched on accepted start
- busy  output  1  high in STEP and DONE
- done  output  1  one-cycle completion pulse
- product  output  WIDTH  low WIDTH bits of op_a×op_b; held until next completion
- alu_a  output  WIDTH  ALU operand a
- alu_b  output  WIDTH  ALU operand b
- alu_ctrl  output  4  ALU control
- alu_result  input  WIDTH  ALU result; carry not used

## Operation
- Internal registers: acc, mc (multiplicand), mp (multiplier), cnt (0..WIDTH-1).
- States: IDLE, STEP, DONE.
- IDLE with start=1 at an edge:
  - acc←0, mc←op_a, mp←op_b, cnt←0.
  - Go to STEP.
- IDLE with start=0: stay in IDLE.
- STEP, add cycle (mp[0]=1):
  - alu_a=acc, alu_b=mc, alu_ctrl=ALU_ADD.
  - At the edge: acc←alu_result, mp[0]←0.
  - Stay in STEP.
- STEP, shift cycle (mp[0]=0):
  - mc←mc<<1, mp←mp>>1, cnt←cnt+1.
  - Leave for DONE when the termination condition holds (see Configuration); otherwise stay in STEP.
- On entry to DONE: product←acc.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- When not in an add cycle: alu_a=0, alu_b=0, alu_ctrl=4'b0000.
- Arithmetic is mod 2^WIDTH. Overflow is discarded. The result is correct for both signed and unsigned operands.
- start is ignored in STEP and DONE, and operand changes while busy have no effect. A start sampled in the DONE cycle is ignored; the requester re-asserts it in IDLE.
- reset_n low, at any time, immediately forces:
  - state=IDLE
  - busy=0, done=0, product=0
  - acc/mc/mp/cnt=0
  - alu_a=0, alu_b=0, alu_ctrl=0
- An in-flight operation is discarded on reset and not resumed.

## Timing
- Reset value of every output is 0, including alu_ctrl=4'b0000.
- Start accepted at edge E0. DONE is entered at edge E0+N, so done and the new product are visible in the cycle after edge E0+N; busy falls at E0+N+1.
- Without the macro: N = WIDTH + popcount(op_b).
- With the macro: N = (index of highest set bit of op_b + 1) + popcount(op_b). For op_b=0, N=1.
- Earliest next start acceptance: edge E0+N+2.
- The ALU is combinational and its result is captured in the same cycle. Exactly popcount(op_b) cycles carry alu_ctrl=ALU_ADD.
- product changes only on DONE entry and on reset.

## Configuration
- MUL_EARLY_EXIT_EN defined: a shift cycle goes to DONE when (mp>>1)==0 or cnt==WIDTH-1.
- MUL_EARLY_EXIT_EN undefined: a shift cycle goes to DONE only when cnt==WIDTH-1. Latency is fixed at WIDTH + popcount(op_b).
- The product value is identical in both builds.

## Test plan
- op_a=7, op_b=6: product=42, done one cycle, 2 ADD cycles. N=66 without the macro, N=5 with it.
- op_a=12345, op_b=0: product=0, no ADD cycles. N=64 without the macro, N=1 with it.
- op_a=64'hFFFF_FFFF_FFFF_FFFF, op_b=3: product=64'hFFFF_FFFF_FFFF_FFFD (−3). N=4 with the macro.
- op_a=op_b=64'h1_0000_0000: product=0 (truncated), done asserted, no error. N=34 with the macro, N=65 without.
  - Carried out in the without-macro build (N=65) and repeated in the with-macro build (N=34).
- Start op_a=5, op_b=5; hold start=1 and change operands to 9/9 while busy:
  - Result is product=25 (only the first request is accepted).
  - A start raised after busy falls returns 81.
- Assert reset_n=0 at cycle 10 of a 7×6 operation:
  - busy=0, done=0, product=0, alu_ctrl=0 immediately, before the next edge.
  - After release, 3×4 completes with product=12.
